// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the memory-stage controller.
package mem_stage_pkg;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_WBUF_DEPTH = 4;

   // Memory-side controller states
   typedef enum logic [1:0] {
      MS_IDLE     = 2'd0,
      MS_WR_ISSUE = 2'd1,
      MS_RD_ISSUE = 2'd2
   } ms_state_t;

endpackage

// File: rtl/mem_stage_wb_write_buffer.sv
// Posted-write FIFO with a parallel youngest-match lookup for load forwarding.
// The head entry stays resident while its write is in flight and is only
// removed by pop, so it still forwards until the memory acknowledges it.
module write_buffer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [PW:0]       cnt;
   logic [PW-1:0]     idx;

   assign full      = (cnt == FULL_CNT);
   assign empty     = (cnt == '0);
   assign head_addr = addr_q[head];
   assign head_data = data_q[head];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage, written at the tail
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail] <= push_addr;
         data_q[tail] <= push_data;
      end
   end

   // Walk from oldest to youngest by age behind the tail; the youngest match wins
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         idx = tail - PW'(k+1);
         if (k < int'(cnt) && addr_q[idx] == lookup_addr) begin
            hit      = 1'b1;
            hit_data = data_q[idx];
         end
      end
   end

endmodule

// File: rtl/mem_stage_wb.sv
// Memory-stage controller: posts stores into a write buffer, forwards loads
// from it, drains it in order ahead of any load miss, and reports errors.
module mem_stage_wb import mem_stage_pkg::*; #(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int WBUF_DEPTH  = DEF_WBUF_DEPTH,
   parameter int ALIGN_CHECK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic [DATA_W-1:0] ld_data,
   output logic              ld_valid,
   output logic [ADDR_W-1:0] addr_out,
   output logic              wbuf_empty,
   output logic              err,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   input  logic              mem_err
);

   ms_state_t         state;
   logic              misalign;
   logic              req_err;
   logic              ld_req;
   logic              st_req;
   logic              ld_miss;
   logic              wr_done;
   logic              rd_done;
   logic              push;
   logic              wb_full;
   logic              wb_empty;
   logic              wb_hit;
   logic [ADDR_W-1:0] wb_head_addr;
   logic [DATA_W-1:0] wb_head_data;
   logic [DATA_W-1:0] wb_hit_data;

   // Request classification; an erroneous request is neither a load nor a store
   assign misalign = (ALIGN_CHECK != 0) && req_addr[0];
   assign req_err  = (req_rd | req_wr) & (misalign | (req_rd & req_wr));
   assign ld_req   = req_rd & ~req_wr & ~misalign;
   assign st_req   = req_wr & ~req_rd & ~misalign;
   assign ld_miss  = ld_req & ~wb_hit;
   assign wr_done  = (state == MS_WR_ISSUE) & mem_done;
   assign rd_done  = (state == MS_RD_ISSUE) & mem_done;
   assign push     = st_req & ~wb_full;

   // A same-cycle pop does not relieve a full buffer; a miss releases on its own done
   assign stall      = (st_req & wb_full) | (ld_miss & ~rd_done);
   assign addr_out   = req_addr;
   assign wbuf_empty = wb_empty & (state != MS_WR_ISSUE);

   write_buffer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (WBUF_DEPTH)
   ) u_wbuf (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_addr   (req_addr),
      .push_data   (req_wdata),
      .pop         (wr_done),
      .lookup_addr (req_addr),
      .full        (wb_full),
      .empty       (wb_empty),
      .head_addr   (wb_head_addr),
      .head_data   (wb_head_data),
      .hit         (wb_hit),
      .hit_data    (wb_hit_data)
   );

   // Drain writes before any read; a push into an empty buffer issues immediately
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= MS_IDLE;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            MS_IDLE: begin
               if (!wb_empty || push) begin
                  state     <= MS_WR_ISSUE;
                  mem_wr    <= 1'b1;
                  mem_addr  <= wb_empty ? req_addr  : wb_head_addr;
                  mem_wdata <= wb_empty ? req_wdata : wb_head_data;
               end else if (ld_miss) begin
                  state    <= MS_RD_ISSUE;
                  mem_rd   <= 1'b1;
                  mem_addr <= req_addr;
               end
            end
            MS_WR_ISSUE: begin
               if (mem_done) begin
                  state  <= MS_IDLE;
                  mem_wr <= 1'b0;
               end
            end
            MS_RD_ISSUE: begin
               if (mem_done) begin
                  state  <= MS_IDLE;
                  mem_rd <= 1'b0;
               end
            end
            default: begin
               state  <= MS_IDLE;
               mem_rd <= 1'b0;
               mem_wr <= 1'b0;
            end
         endcase
      end
   end

   // Load result register: forward hits and successful read returns
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_data  <= '0;
         ld_valid <= 1'b0;
      end else begin
         ld_valid <= (ld_req & wb_hit) | (rd_done & ~mem_err);
         if (ld_req & wb_hit)
            ld_data <= wb_hit_data;
         else if (rd_done & ~mem_err)
            ld_data <= mem_rdata;
      end
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (req_err || (mem_done && mem_err && state != MS_IDLE))
         err <= 1'b1;
   end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Scoreboard bench for mem_stage_wb: an architectural memory model predicts
// every load result, a behavioural memory system answers the handshake.
module tb_mem_stage_wb;

   localparam int DW = 16;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_rd, req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          stall;
   logic [DW-1:0] ld_data;
   logic          ld_valid;
   logic [AW-1:0] addr_out;
   logic          wbuf_empty;
   logic          err;
   logic          mem_rd, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_done;
   logic          mem_err;

   always #5 clk = ~clk;

   mem_stage_wb #(.DATA_W(DW), .ADDR_W(AW), .WBUF_DEPTH(4), .ALIGN_CHECK(1)) dut (
      .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
      .addr_out(addr_out), .wbuf_empty(wbuf_empty), .err(err), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err)
   );

   typedef struct packed { logic wr; logic [15:0] addr; } txn_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] ref_mem [256];
   logic [15:0] mem_sys [256];
   logic [15:0] exp_q [$];
   txn_t        log_q [$];
   int          lat = 2;
   bit          mem_hold = 1'b0;
   bit          err_inj = 1'b0;

   function automatic logic [15:0] init_val(int i);
      return 16'(i * 257) ^ 16'h5A3C;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural memory system: counts busy cycles, then pulses done for one cycle
   initial begin
      int busy;
      busy = 0; mem_done = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            mem_done = 1'b0; mem_err = 1'b0; busy = 0;
         end else if (mem_done) begin
            mem_done = 1'b0; mem_err = 1'b0; busy = 0;
         end else if ((mem_rd || mem_wr) && !mem_hold) begin
            busy++;
            if (busy >= lat) begin
               if (mem_wr) begin
                  mem_sys[mem_addr[7:0]] = mem_wdata;
                  log_q.push_back({1'b1, mem_addr});
               end else begin
                  mem_rdata = mem_sys[mem_addr[7:0]];
                  log_q.push_back({1'b0, mem_addr});
               end
               mem_err  = err_inj;
               mem_done = 1'b1;
            end
         end
      end
   end

   // Monitor: every ld_valid pulse must match the oldest outstanding expectation
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (!rst && ld_valid) begin
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL ld_unexpected: got ld_valid=1 data=0x%0h, expected no load result", ld_data);
            end else begin
               e = exp_q.pop_front();
               check("ld_data", 32'(ld_data), 32'(e));
            end
         end
      end
   end

   // Present one request, hold it while stalled, update the reference at acceptance
   task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input bit mfail, output int stalls, output bit done_seen, output int logn);
      bit bad;
      @(negedge clk);
      req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
      #3;
      stalls = 0;
      while (stall === 1'b1) begin
         stalls++;
         if (stalls > 400) begin
            vectors++; miscompares++;
            $display("FAIL issue_timeout: got stall held 400 cycles, expected release");
            break;
         end
         @(negedge clk); #3;
      end
      done_seen = mem_done;
      logn      = log_q.size();
      bad = (rd && wr) || a[0] || mfail;
      if (!bad) begin
         if (wr) ref_mem[a[7:0]] = d;
         else if (rd) exp_q.push_back(ref_mem[a[7:0]]);
      end
      @(posedge clk); #1;
      req_rd = 1'b0; req_wr = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!(wbuf_empty && !mem_rd && !mem_wr) && n < 300) begin
         n++;
         @(negedge clk);
      end
      check(name, 32'(wbuf_empty), 32'd1);
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   function automatic int image_diffs();
      int m;
      m = 0;
      for (int i = 0; i < 256; i++) if (ref_mem[i] !== mem_sys[i]) m++;
      return m;
   endfunction

   initial begin
      int s; bit dn; int ln; int s5; bit dn5; int ln5;
      logic [15:0] a, d;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = init_val(i);
         mem_sys[i] = init_val(i);
      end
      rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ld_valid", 32'(ld_valid), 0);
      check("rst_ld_data", 32'(ld_data), 0);
      check("rst_err", 32'(err), 0);
      check("rst_mem_rd", 32'(mem_rd), 0);
      check("rst_mem_wr", 32'(mem_wr), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_wbuf_empty", 32'(wbuf_empty), 1);
      check("rst_stall", 32'(stall), 0);
      rst = 1'b0;

      // store then drain
      lat = 2;
      issue(0, 1, 16'h0010, 16'hBEEF, 0, s, dn, ln);
      check("st_stall", s, 0);
      @(negedge clk);
      check("st_mem_wr", 32'(mem_wr), 1);
      check("st_mem_addr", 32'(mem_addr), 32'h0010);
      check("st_mem_wdata", 32'(mem_wdata), 32'hBEEF);
      wait_idle("st_drain");
      check("st_mem_image", 32'(mem_sys[8'h10]), 32'hBEEF);

      // forwarding from the youngest entry, memory held
      mem_hold = 1'b1;
      issue(0, 1, 16'h0020, 16'h1111, 0, s, dn, ln);
      issue(0, 1, 16'h0020, 16'h2222, 0, s, dn, ln);
      issue(1, 0, 16'h0020, 16'h0000, 0, s, dn, ln);
      check("fwd_stall", s, 0);
      @(negedge clk);
      check("fwd_ld_valid", 32'(ld_valid), 1);
      check("fwd_ld_data", 32'(ld_data), 32'h2222);
      check("fwd_no_mem_rd", 32'(mem_rd), 0);
      mem_hold = 1'b0;
      wait_idle("fwd_drain");

      // ordering: buffered writes complete before the read miss
      lat = 3;
      log_q.delete();
      issue(0, 1, 16'h0030, 16'hA5A5, 0, s, dn, ln);
      issue(0, 1, 16'h0032, 16'h5A5A, 0, s, dn, ln);
      issue(1, 0, 16'h0040, 16'h0000, 0, s, dn, ln);
      check("ord_stall_falls_at_done", 32'(dn), 1);
      check("ord_txn_count", ln, 3);
      if (log_q.size() >= 3) begin
         check("ord_first", 32'(log_q[0]), 32'({1'b1, 16'h0030}));
         check("ord_second", 32'(log_q[1]), 32'({1'b1, 16'h0032}));
         check("ord_third", 32'(log_q[2]), 32'({1'b0, 16'h0040}));
      end
      wait_idle("ord_drain");

      // load miss with an empty buffer: stalls in cycles 0 and 1, done in cycle 2
      lat = 2;
      issue(1, 0, 16'h0050, 16'h0000, 0, s, dn, ln);
      check("miss_stall_cycles", s, 2);
      check("miss_done_seen", 32'(dn), 1);
      wait_idle("miss_idle");

      // full buffer: fifth store waits for the first pop
      mem_hold = 1'b1;
      log_q.delete();
      for (int i = 0; i < 4; i++) begin
         issue(0, 1, 16'(16'h0080 + 2*i), 16'(16'hC000 + i), 0, s, dn, ln);
         check("full_fill_stall", s, 0);
      end
      fork
         issue(0, 1, 16'h0088, 16'hC004, 0, s5, dn5, ln5);
         begin
            repeat (6) @(posedge clk);
            #2 mem_hold = 1'b0;
         end
      join
      check("full_fifth_stalled", 32'(s5 >= 6), 1);
      check("full_accept_after_one_pop", ln5, 1);
      wait_idle("full_drain");
      check("full_mem_image", image_diffs(), 0);

      // randomized traffic against the architectural model
      for (int n = 0; n < 300; n++) begin
         int op;
         op  = int'($urandom_range(0, 3));
         a   = 16'($urandom_range(0, 15) * 2);
         d   = 16'($urandom);
         lat = int'($urandom_range(2, 4));
         if (op == 0)      issue(1, 0, a, 16'h0000, 0, s, dn, ln);
         else if (op <= 2) issue(0, 1, a, d, 0, s, dn, ln);
         else              @(negedge clk);
      end
      wait_idle("rand_drain");
      repeat (3) @(negedge clk);
      check("rand_all_loads_returned", exp_q.size(), 0);
      check("rand_mem_image", image_diffs(), 0);

      // misaligned load
      issue(1, 0, 16'h0031, 16'h0000, 0, s, dn, ln);
      check("mis_stall", s, 0);
      @(negedge clk);
      check("mis_err", 32'(err), 1);
      check("mis_no_mem_rd", 32'(mem_rd), 0);
      repeat (3) @(negedge clk);
      check("mis_err_sticky", 32'(err), 1);
      pulse_reset();
      check("err_cleared", 32'(err), 0);

      // simultaneous load and store
      issue(1, 1, 16'h0044, 16'h7777, 0, s, dn, ln);
      check("both_stall", s, 0);
      @(negedge clk);
      check("both_err", 32'(err), 1);
      check("both_no_mem_wr", 32'(mem_wr), 0);
      pulse_reset();

      // memory error on a read
      err_inj = 1'b1; lat = 2;
      issue(1, 0, 16'h0060, 16'h0000, 1, s, dn, ln);
      check("merr_stall", s, 2);
      @(negedge clk);
      check("merr_err", 32'(err), 1);
      check("merr_no_ld_valid", 32'(ld_valid), 0);
      err_inj = 1'b0;
      pulse_reset();

      // reset while a write is in flight discards everything
      issue(1, 0, 16'h0033, 16'h0000, 0, s, dn, ln);
      mem_hold = 1'b1;
      issue(0, 1, 16'h0070, 16'h1234, 0, s, dn, ln);
      issue(0, 1, 16'h0072, 16'h4321, 0, s, dn, ln);
      @(negedge clk);
      check("rstd_mem_wr_before", 32'(mem_wr), 1);
      check("rstd_err_before", 32'(err), 1);
      log_q.delete();
      rst = 1'b1;
      @(negedge clk);
      check("rstd_mem_wr", 32'(mem_wr), 0);
      check("rstd_wbuf_empty", 32'(wbuf_empty), 1);
      check("rstd_err", 32'(err), 0);
      rst = 1'b0; mem_hold = 1'b0;
      repeat (8) @(negedge clk);
      check("rstd_no_writes_after", log_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #400000;
      $display("FAIL global_timeout: got no completion, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_stage_wb.md
# mem_stage_wb

Parametrised memory-stage controller with a posted write buffer. It sits between the EX/MEM pipeline register and a multi-cycle memory system that uses a Rd/Wr/Done handshake. Stores retire into a small FIFO so the pipeline does not stall on them, and loads forward from that FIFO when the address matches. The block drives a single `stall` to the pipeline and returns load data through a registered output.

## Interface
- `DATA_W`, 16: data width, in bits.
- `ADDR_W`, 16: address width, in bits.
- `WBUF_DEPTH`, 4: number of write-buffer entries. Must be a power of two and at least 2.
- `ALIGN_CHECK`, 1: when 1, an access with `req_addr[0]=1` is an error.
- `clk`  in  1: the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_rd`  in  1: load request. Held by the pipeline while `stall=1`.
- `req_wr`  in  1: store request. Held by the pipeline while `stall=1`.
- `req_addr`  in  ADDR_W: access address. Also the pass-through value for `addr_out`.
- `req_wdata`  in  DATA_W: store data.
- `stall`  out  1: the pipeline must hold its request. Combinational.
- `ld_data`  out  DATA_W: registered load result.
- `ld_valid`  out  1: one-cycle pulse marking a new `ld_data`.
- `addr_out`  out  ADDR_W: `req_addr` passed through combinationally.
- `wbuf_empty`  out  1: the buffer is empty and no write is in flight. Used to gate halt and dump.
- `err`  out  1: sticky error flag.
- `mem_rd`, `mem_wr`  out  1 each: registered memory requests.
- `mem_addr`  out  ADDR_W: registered memory address.
- `mem_wdata`  out  DATA_W: registered memory write data.
- `mem_rdata`  in  DATA_W: read data, valid only when `mem_done=1`.
- `mem_done`  in  1: single-cycle completion pulse from the memory system.
- `mem_err`  in  1: error reported by the memory system, sampled when `mem_done=1`.

## Operation
- **FSM states:** IDLE, WR_ISSUE, RD_ISSUE.
  - IDLE → WR_ISSUE: the buffer is non-empty. This takes priority over a pending load miss, so memory ordering is preserved.
  - IDLE → RD_ISSUE: the buffer is empty and a load miss is pending.
  - WR_ISSUE → IDLE: on `mem_done`, and the buffer head is popped in that cycle.
  - RD_ISSUE → IDLE: on `mem_done`.
- **Memory request outputs:** `mem_rd`/`mem_wr` are asserted exactly while the FSM is in RD_ISSUE/WR_ISSUE. `mem_addr` and `mem_wdata` are loaded on entry to those states and held stable until `mem_done`.
- **Store:**
  - Buffer not full: push {addr, data} and drive `stall=0`.
  - Buffer full: `stall=1`. A pop in the same cycle does not free a slot until the next cycle.
- **Load, forward hit:** the youngest valid entry whose address equals `req_addr` supplies `ld_data`, and `stall=0`. No memory access is made.
- **Load, miss:** `stall=1` until the `mem_done` of its read. In that cycle `stall=0`, `ld_data <= mem_rdata`, and `ld_valid` pulses in the next cycle.
- **Forwarding compare:** runs only against entries still in the buffer. An entry being popped in the same cycle still matches.
- **Error cases:** a misaligned access (when `ALIGN_CHECK=1`), `req_rd & req_wr`, or `mem_err` at `mem_done`:
  - The request completes with `stall=0`.
  - It makes no memory access and no buffer push; `ld_valid` does not pulse.
  - `err` sets on the next edge and stays set until `rst`.
- **No request:** when neither `req_rd` nor `req_wr` is asserted, `stall=0`.

## Timing
- **Reset values:**
  - `stall` follows its combinational rules; with no request it is 0.
  - Outputs cleared: `ld_data`, `ld_valid`, `err`, `mem_rd`, `mem_wr`, `mem_addr`, `mem_wdata` all 0; `wbuf_empty` 1.
  - Internal state: buffer pointers and count cleared; FSM in IDLE.
- **Reset mid-operation:** `mem_rd`/`mem_wr` drop on the reset edge. An in-flight write and all buffered writes are discarded.
- **Store latency:** 0 stall cycles when the buffer is not full. The first drain request appears 1 cycle after the push.
- **Load miss latency, buffer empty:**
  - Cycle 0: request presented, `stall=1`.
  - Cycle 1: `mem_rd=1`.
  - Cycle k ≥ 2: `mem_done`, `stall=0`.
  - Cycle k+1: `ld_valid=1`.
- **Load miss latency, N entries buffered:** all N writes complete first, then the read.
- **Forward hit:** `stall=0` in cycle 0 and `ld_valid` in cycle 1.
- **Buffer pointers:** wrap modulo `WBUF_DEPTH`. Count range is 0..`WBUF_DEPTH`.
- **Push and pop in one cycle:** allowed when not full; the count is unchanged.

## Structure
- **Package `mem_stage_pkg`:** the FSM state enum (`MS_IDLE`, `MS_WR_ISSUE`, `MS_RD_ISSUE`) and default width constants.
- **Sub-module `write_buffer`:**
  - Parametrised FIFO with a full/empty count and head outputs.
  - Parallel address compare returning hit plus the youngest matching data; youngest is selected by age relative to the tail.
- **Top level:** the FSM, stall logic, error logic and output registers.

## Test plan
- **Store then drain:** store A=0x0010, D=0xBEEF into an idle block → `stall=0`; `mem_wr=1`, `mem_addr=0x0010`, `mem_wdata=0xBEEF` the next cycle; `wbuf_empty=1` after `mem_done`.
- **Forwarding:** stores to 0x0020 (0x1111), then 0x0020 (0x2222), then a load of 0x0020 → `stall=0`, `ld_data=0x2222`, `ld_valid` 1 cycle later, no `mem_rd`.
- **Ordering:** 2 stores to 0x0030 and 0x0032, then a load of 0x0040 with a 3-cycle memory → both `mem_wr` transactions happen before `mem_rd`; `ld_data = mem_rdata` and `stall` falls exactly in the read's `mem_done` cycle.
- **Full buffer:** `WBUF_DEPTH=4`, memory stalled, 5 back-to-back stores → the fifth sees `stall=1` until the first pop, then is accepted.
- **Error cases:** load of 0x0031 → `stall=0`, no `mem_rd`, `err=1` the next cycle and held. Separately, `req_rd` and `req_wr` asserted together → `err=1`.
- **Reset during drain:** `rst` asserted while `mem_wr=1` → `mem_wr=0`, `wbuf_empty=1`, `err=0` after the edge.
